mix_columns_iter: RTL and testbench

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

---
 rtl/mix_columns_iter_if.sv | 21 ++
 rtl/mix_columns_iter.sv | 140 ++++++++++++++
 tb/tb_mix_columns_iter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_columns_iter_if.sv
// Handshake and data bundle for mix_columns_iter: input state offer, result drain and busy status.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         inv_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, inv_mode, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, inv_mode, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES (Inv)MixColumns: COLS_PER_CYCLE columns per compute cycle, in place in a working register.
// Optional inverse datapath enabled by defining MIXCOL_INV_EN.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int STATE_W        = 128
) (
  input logic clk,
  input logic rst_n,
  mix_columns_iter_if.slave bus
);

  if (STATE_W != 128) begin : g_bad_state_w
    $error("mix_columns_iter: STATE_W must be 128");
  end
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         NGROUPS  = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP = 2'(NGROUPS - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_q, out_d;
  logic         started_q;
  logic [127:0] mixed;
  logic [1:0]   colIdx [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 2a0+3a1+a2+a3 rewritten as xtime(a0^a1)^a1^a2^a3 so each row needs one xtime.
  function automatic logic [31:0] mixFwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = c;
    t = a0 ^ a1 ^ a2 ^ a3;
    return {xtime(a0 ^ a1) ^ t ^ a0, xtime(a1 ^ a2) ^ t ^ a1,
            xtime(a2 ^ a3) ^ t ^ a2, xtime(a3 ^ a0) ^ t ^ a3};
  endfunction

`ifdef MIXCOL_INV_EN
  // Inverse matrix factors as forward * circ{05,00,04,00}, so pre-mix then reuse mixFwd.
  function automatic logic [31:0] mixInv(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, u, v;
    {a0, a1, a2, a3} = c;
    u = xtime(xtime(a0 ^ a2));
    v = xtime(xtime(a1 ^ a3));
    return mixFwd({a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v});
  endfunction

  logic inv_q, inv_d;
`else
  logic unusedInv;
  assign unusedInv = bus.inv_mode;
`endif

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col_idx
    assign colIdx[k] = 2'(int'(cnt_q) * COLS_PER_CYCLE + k);
  end

  // Column c lives at bits [32*(3-c) +: 32]; 3-c of a 2-bit index is just its complement.
  always_comb begin
    mixed = work_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
`ifdef MIXCOL_INV_EN
      mixed[{~colIdx[k], 5'b0} +: 32] = inv_q ? mixInv(work_q[{~colIdx[k], 5'b0} +: 32])
                                              : mixFwd(work_q[{~colIdx[k], 5'b0} +: 32]);
`else
      mixed[{~colIdx[k], 5'b0} +: 32] = mixFwd(work_q[{~colIdx[k], 5'b0} +: 32]);
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
`ifdef MIXCOL_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && started_q) begin
          work_d  = bus.in_state;
`ifdef MIXCOL_INV_EN
          inv_d   = bus.inv_mode;
`endif
          cnt_d   = 2'd0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        work_d = mixed;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == LAST_GRP) begin
          out_d   = mixed;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // started_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      work_q    <= '0;
      out_q     <= '0;
      started_q <= 1'b0;
`ifdef MIXCOL_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      out_q     <= out_d;
      started_q <= 1'b1;
`ifdef MIXCOL_INV_EN
      inv_q     <= inv_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && started_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == COMPUTE);
  assign bus.out_state = out_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Scoreboard bench for mix_columns_iter: directed vectors, backpressure, reset abort and random back-to-back traffic.
// Expected results come from a GF(2^8) matrix-multiply model; inverse expectations follow MIXCOL_INV_EN.
module tb_mix_columns_iter;
  localparam int COLS   = 1;
  localparam int LAT    = 4 / COLS;
  localparam int PERIOD = LAT + 2;
  localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  logic clk;
  logic rst_n;
  mix_columns_iter_if mc ();

  mix_columns_iter #(.COLS_PER_CYCLE(COLS), .STATE_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mc)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int prevHs = -1;
  bit btbPhase = 0;
  logic [127:0] expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // out[r][c] = XOR_j base[(j-r) mod 4] * in[j][c]; bytes run MSB-first in (c, r) order.
  function automatic logic [127:0] refMix(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4][4];
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] res = '0;
    logic         effInv;
`ifdef MIXCOL_INV_EN
    effInv = inv;
`else
    effInv = 1'b0 & inv;
`endif
    if (effInv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else        base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int k = 0; k < 16; k++) m[k / 4][k % 4] = 8'(s >> (120 - 8 * k));
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gfMul(base[(j - r + 4) % 4], m[c][j]);
        res = {res[119:0], acc};
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] st, input logic inv);
    int n = 0;
    mc.in_state = st;
    mc.inv_mode = inv;
    mc.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!mc.in_ready && n < 100);
    if (!mc.in_ready) begin
      checkOutput("accept_timeout", 128'(mc.in_ready), 128'd1);
    end else begin
      expQ.push_back(refMix(st, inv));
      @(posedge clk);
      #1;
    end
    mc.in_valid = 1'b0;
  endtask

  task automatic waitValid();
    int n = 0;
    while (!mc.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!mc.out_valid) checkOutput("valid_timeout", 128'(mc.out_valid), 128'd1);
  endtask

  task automatic drainOne();
    waitValid();
    mc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    mc.out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && mc.out_valid && mc.out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", mc.out_state, 128'hx);
      end else begin
        checkOutput("scoreboard", mc.out_state, expQ.pop_front());
      end
      if (btbPhase) begin
        if (prevHs >= 0) checkOutput("throughput", 128'(cyc - prevHs), 128'(PERIOD));
        prevHs = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit ok1, ok2, ok3, sawValid;
    logic [127:0] held;
    clk = 1'b0;
    rst_n = 1'b0;
    mc.in_valid = 1'b0;
    mc.in_state = '0;
    mc.inv_mode = 1'b0;
    mc.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 128'(mc.in_ready), 128'd0);
    checkOutput("reset_out_valid", 128'(mc.out_valid), 128'd0);
    checkOutput("reset_busy", 128'(mc.busy), 128'd0);
    checkOutput("reset_out_state", mc.out_state, 128'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", 128'(mc.in_ready), 128'd0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", 128'(mc.in_ready), 128'd1);

    // Forward vector, latency and backpressure
    applyStimulus(VEC_A, 1'b0);
    checkOutput("busy_in_compute", 128'(mc.busy), 128'd1);
    checkOutput("ready_in_compute", 128'(mc.in_ready), 128'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mc.out_valid && n < 20);
    checkOutput("latency", 128'(n), 128'(LAT));
    checkOutput("fwd_vector", mc.out_state, VEC_B);
    held = mc.out_state;
    ok1 = 1; ok2 = 1; ok3 = 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (mc.out_valid !== 1'b1) ok1 = 0;
      if (mc.out_state !== held) ok2 = 0;
      if (mc.in_ready !== 1'b0) ok3 = 0;
    end
    checkOutput("bp_valid_held", 128'(ok1), 128'd1);
    checkOutput("bp_state_stable", 128'(ok2), 128'd1);
    checkOutput("bp_ready_low", 128'(ok3), 128'd1);
    mc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    mc.out_ready = 1'b0;
    checkOutput("drain_valid_low", 128'(mc.out_valid), 128'd0);
    checkOutput("drain_ready_high", 128'(mc.in_ready), 128'd1);
    checkOutput("state_held_after_drain", mc.out_state, VEC_B);

    // Input changes after capture must not disturb the result
    applyStimulus(VEC_A, 1'b0);
    mc.in_state = '1;
    mc.inv_mode = 1'b1;
    waitValid();
    checkOutput("input_change", mc.out_state, VEC_B);
    drainOne();

    // Inverse round trip (forward result when the inverse path is absent)
    applyStimulus(VEC_B, 1'b1);
    waitValid();
`ifdef MIXCOL_INV_EN
    checkOutput("inv_vector", mc.out_state, VEC_A);
`else
    checkOutput("inv_ignored", mc.out_state, refMix(VEC_B, 1'b0));
`endif
    drainOne();

    // Reset abort during compute
    applyStimulus(VEC_A, 1'b0);
    void'(expQ.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 128'(mc.out_valid), 128'd0);
    checkOutput("abort_busy", 128'(mc.busy), 128'd0);
    checkOutput("abort_in_ready", 128'(mc.in_ready), 128'd0);
    checkOutput("abort_out_state", mc.out_state, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_ready_after", 128'(mc.in_ready), 128'd1);
    sawValid = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (mc.out_valid) sawValid = 1;
    end
    checkOutput("abort_no_result", 128'(sawValid), 128'd0);

    // Random back-to-back traffic with the consumer always ready
    mc.out_ready = 1'b1;
    prevHs = -1;
    btbPhase = 1;
    for (int i = 0; i < 100; i++) begin
      applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
    end
    n = 0;
    while (expQ.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    btbPhase = 0;
    mc.out_ready = 1'b0;
    checkOutput("queue_empty", 128'(expQ.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
